// File: rtl/hex_bus_arbiter_if.sv
// Write-port bundle between the bus requesters and the hex display arbiter.
// Requester lanes are packed; lane k uses the k-th slice of each vector.
interface hex_bus_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32
);
    logic [N_REQ-1:0]        req_i;
    logic [N_REQ-1:0]        we_i;
    logic [N_REQ-1:0]        last_i;
    logic [N_REQ*ADDR_W-1:0] addr_i;
    logic [N_REQ*32-1:0]     wdata_i;
    logic [N_REQ*4-1:0]      be_i;
    logic [N_REQ-1:0]        gnt_o;
    logic [N_REQ-1:0]        ack_o;
    logic                    m_we_o;
    logic [ADDR_W-1:0]       m_addr_o;
    logic [31:0]             m_wdata_o;
    logic [3:0]              m_be_o;
    logic                    busy_o;
    logic [2:0]              owner_o;

    modport master (
        output req_i, we_i, last_i, addr_i, wdata_i, be_i,
        input  gnt_o, ack_o, m_we_o, m_addr_o, m_wdata_o, m_be_o, busy_o, owner_o
    );

    modport slave (
        input  req_i, we_i, last_i, addr_i, wdata_i, be_i,
        output gnt_o, ack_o, m_we_o, m_addr_o, m_wdata_o, m_be_o, busy_o, owner_o
    );
endinterface

// File: rtl/hex_bus_arbiter.sv
// Round-robin arbiter sharing the hex display write port between N_REQ requesters.
// Optional idle-owner watchdog: define HEX_BUS_ARBITER_WATCHDOG_EN (adds wd_evt_o).
module hex_bus_arbiter #(
    parameter int N_REQ     = 2,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 8,
    parameter int WD_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
`ifdef HEX_BUS_ARBITER_WATCHDOG_EN
    output logic wd_evt_o,
`endif
    hex_bus_arbiter_if.slave bus
);
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W  = $clog2(MAX_BURST + 1);
    localparam int IDLE_W = $clog2(WD_CYCLES + 1);

    if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1 || WD_CYCLES < 1) begin : g_bad_param
        $error("hex_bus_arbiter: parameter out of range");
    end

    typedef enum logic {IDLE, OWN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   own_q, own_d, ptr_q, ptr_d, win;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic               any_req, accept, release_now, wd_hit;

    logic [N_REQ-1:0]   gnt_q, gnt_d, ack_q, ack_d;
    logic               m_we_q, m_we_d, busy_q, busy_d, wd_evt_q, wd_evt_d;
    logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
    logic [31:0]        m_wdata_q, m_wdata_d;
    logic [3:0]         m_be_q, m_be_d;

    // First requester strictly after the pointer, wrapping around.
    always_comb begin
        logic [IDX_W-1:0] idx;
        win     = ptr_q;
        any_req = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IDX_W'((int'(ptr_q) + i) % N_REQ);
            if (!any_req && bus.req_i[idx]) begin
                any_req = 1'b1;
                win     = idx;
            end
        end
    end

    assign accept = (state_q == OWN) && bus.req_i[own_q] && bus.we_i[own_q];

`ifdef HEX_BUS_ARBITER_WATCHDOG_EN
    assign wd_hit = (state_q == OWN) && bus.req_i[own_q] && !accept
                    && (idle_q == IDLE_W'(WD_CYCLES - 1));
`else
    assign wd_hit = 1'b0;
`endif

    assign release_now = (state_q == OWN) &&
                         ((accept && bus.last_i[own_q]) ||
                          (accept && (cnt_q == CNT_W'(MAX_BURST - 1))) ||
                          !bus.req_i[own_q] || wd_hit);

    // State register: every flop, including the registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            own_q     <= '0;
            ptr_q     <= IDX_W'(N_REQ - 1);
            cnt_q     <= '0;
            idle_q    <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_be_q    <= '0;
            busy_q    <= 1'b0;
            wd_evt_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_be_q    <= m_be_d;
            busy_q    <= busy_d;
            wd_evt_q  <= wd_evt_d;
        end
    end

    // Next-state logic; the pointer moves only on release, never while arbitrating.
    always_comb begin
        // NOTE: every target gets a default up front so no path infers a latch.
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = OWN;
                    own_d   = win;
                    cnt_d   = '0;
                    idle_d  = '0;
                end
            end
            OWN: begin
                if (accept) begin
                    cnt_d  = cnt_q + 1'b1;
                    idle_d = '0;
                end else if (bus.req_i[own_q]) begin
                    idle_d = idle_q + 1'b1;
                end
                if (release_now) begin
                    state_d = IDLE;
                    ptr_d   = own_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic feeding the output registers; data lanes hold when idle.
    always_comb begin
        gnt_d     = '0;
        busy_d    = 1'b0;
        ack_d     = '0;
        m_we_d    = accept;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_be_d    = m_be_q;
        wd_evt_d  = wd_hit;
        if (state_d == OWN) begin
            gnt_d[own_d] = 1'b1;
            busy_d       = 1'b1;
        end
        if (accept) begin
            ack_d[own_q] = 1'b1;
            m_addr_d     = bus.addr_i[own_q*ADDR_W +: ADDR_W];
            m_wdata_d    = bus.wdata_i[own_q*32 +: 32];
            m_be_d       = bus.be_i[own_q*4 +: 4];
        end
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.ack_o     = ack_q;
    assign bus.m_we_o    = m_we_q;
    assign bus.m_addr_o  = m_addr_q;
    assign bus.m_wdata_o = m_wdata_q;
    assign bus.m_be_o    = m_be_q;
    assign bus.busy_o    = busy_q;
    assign bus.owner_o   = 3'(own_q);
`ifdef HEX_BUS_ARBITER_WATCHDOG_EN
    assign wd_evt_o      = wd_evt_q;
`endif
endmodule

// File: tb/tb_hex_bus_arbiter.sv
// Directed bench for hex_bus_arbiter (N_REQ=2, MAX_BURST=8) with assertion-based checks.
`timescale 1ns/1ps
module tb_hex_bus_arbiter;
    logic clk_i = 1'b0;
    logic rst_i;
    int   checks   = 0;
    int   failures = 0;
    int   ack_seen = 0;
`ifdef HEX_BUS_ARBITER_WATCHDOG_EN
    logic wd_evt_o;
`endif

    hex_bus_arbiter_if #(.N_REQ(2), .ADDR_W(32)) bus ();

    hex_bus_arbiter #(
        .N_REQ(2), .ADDR_W(32), .MAX_BURST(8), .WD_CYCLES(64)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
`ifdef HEX_BUS_ARBITER_WATCHDOG_EN
        .wd_evt_o (wd_evt_o),
`endif
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
        bus.addr_i[k*32 +: 32]  = addr;
        bus.wdata_i[k*32 +: 32] = wdata;
        bus.be_i[k*4 +: 4]      = be;
    endtask

    task automatic quiet();
        bus.req_i  = '0;
        bus.we_i   = '0;
        bus.last_i = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   bus.gnt_o,     0);
        check({tag, "_ack"},   bus.ack_o,     0);
        check({tag, "_we"},    bus.m_we_o,    0);
        check({tag, "_addr"},  bus.m_addr_o,  0);
        check({tag, "_wdata"}, bus.m_wdata_o, 0);
        check({tag, "_be"},    bus.m_be_o,    0);
        check({tag, "_busy"},  bus.busy_o,    0);
        check({tag, "_owner"}, bus.owner_o,   0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1;
        quiet();
        bus.addr_i = '0; bus.wdata_i = '0; bus.be_i = '0;
        tick(); tick();
        check_all_zero("reset");
        rst_i = 1'b0;

        // Single write from requester 0
        bus.req_i = 2'b01;
        tick();
        check("t1_gnt", bus.gnt_o, 2'b01);
        check("t1_busy", bus.busy_o, 1);
        check("t1_owner", bus.owner_o, 0);
        check("t1_no_we_idle", bus.m_we_o, 0);
        bus.we_i = 2'b01; bus.last_i = 2'b01;
        put(0, 32'h0, 32'h0000_1234, 4'hF);
        tick();
        check("t1_we", bus.m_we_o, 1);
        check("t1_addr", bus.m_addr_o, 32'h0);
        check("t1_wdata", bus.m_wdata_o, 32'h1234);
        check("t1_be", bus.m_be_o, 4'hF);
        check("t1_ack", bus.ack_o, 2'b01);
        check("t1_rel_gnt", bus.gnt_o, 2'b00);
        check("t1_rel_busy", bus.busy_o, 0);
        quiet();
        tick();
        check("t1_idle_we", bus.m_we_o, 0);
        check("t1_idle_ack", bus.ack_o, 0);
        check("t1_hold_wdata", bus.m_wdata_o, 32'h1234);

        // Alternating single-write bursts from reset: 0,1,0,1
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        put(0, 32'h10, 32'hA0, 4'h1);
        put(1, 32'h20, 32'hB1, 4'h2);
        bus.req_i = 2'b11; bus.we_i = 2'b11; bus.last_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_gnt", bus.gnt_o, (i % 2) ? 2'b10 : 2'b01);
            check("t2_owner", bus.owner_o, (i % 2) ? 1 : 0);
            check("t2_no_ack", bus.ack_o, 0);
            tick();
            check("t2_dead_gnt", bus.gnt_o, 0);
            check("t2_ack", bus.ack_o, (i % 2) ? 2'b10 : 2'b01);
            check("t2_addr", bus.m_addr_o, (i % 2) ? 32'h20 : 32'h10);
            check("t2_busy", bus.busy_o, 0);
        end
        quiet();
        tick();
        check("t2_end_gnt", bus.gnt_o, 0);

        // Requester 1: 10 writes, forced release after the 8th
        bus.req_i = 2'b10; bus.we_i = 2'b10; bus.last_i = 2'b00;
        tick();
        check("t3_gnt", bus.gnt_o, 2'b10);
        check("t3_owner", bus.owner_o, 1);
        put(1, 32'h100, 32'hC00, 4'hF);
        ack_seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            ack_seen += int'(bus.ack_o[1]);
            check("t3_ack", bus.ack_o, 2'b10);
            check("t3_addr", bus.m_addr_o, 32'h100 + k);
            check("t3_gnt_burst", bus.gnt_o, (k == 7) ? 2'b00 : 2'b10);
            put(1, 32'h100 + k + 1, 32'hC00 + k + 1, 4'hF);
        end
        tick();
        ack_seen += int'(bus.ack_o[1]);
        check("t3_dead_we", bus.m_we_o, 0);
        check("t3_regrant", bus.gnt_o, 2'b10);
        check("t3_hold_addr", bus.m_addr_o, 32'h107);
        for (int k = 8; k < 10; k++) begin
            tick();
            ack_seen += int'(bus.ack_o[1]);
            check("t3_tail_addr", bus.m_addr_o, 32'h100 + k);
            check("t3_tail_wdata", bus.m_wdata_o, 32'hC00 + k);
            check("t3_tail_gnt", bus.gnt_o, 2'b10);
            put(1, 32'h100 + k + 1, 32'hC00 + k + 1, 4'hF);
        end
        quiet();
        tick();
        ack_seen += int'(bus.ack_o[1]);
        check("t3_drop_gnt", bus.gnt_o, 0);
        check("t3_ack_total", ack_seen, 10);

        // Non-owner write strobe is ignored
        bus.req_i = 2'b01;
        tick();
        check("t4_gnt", bus.gnt_o, 2'b01);
        bus.req_i = 2'b11; bus.we_i = 2'b10;
        put(1, 32'h8, 32'hDEAD, 4'hF);
        tick();
        check("t4_no_ack", bus.ack_o, 0);
        check("t4_no_we", bus.m_we_o, 0);
        check("t4_addr_hold", bus.m_addr_o, 32'h109);
        check("t4_gnt_kept", bus.gnt_o, 2'b01);
        bus.we_i = 2'b01; bus.last_i = 2'b01;
        put(0, 32'h4, 32'h44, 4'h3);
        tick();
        check("t4_own_ack", bus.ack_o, 2'b01);
        check("t4_own_addr", bus.m_addr_o, 32'h4);
        quiet();
        tick();
        check("t4_end_gnt", bus.gnt_o, 0);

        // Reset in the middle of a burst
        bus.req_i = 2'b10;
        tick();
        check("t5_gnt", bus.gnt_o, 2'b10);
        bus.we_i = 2'b10;
        put(1, 32'h200, 32'hE0, 4'h5);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_ack", bus.ack_o, 2'b10);
            put(1, 32'h201 + k, 32'hE1 + k, 4'h5);
        end
        rst_i = 1'b1;
        #1;
        check_all_zero("t5_async");
        quiet();
        bus.req_i = 2'b11;
        tick();
        check("t5_held_gnt", bus.gnt_o, 0);
        rst_i = 1'b0;
        tick();
        check("t5_first_gnt", bus.gnt_o, 2'b01);
        check("t5_first_owner", bus.owner_o, 0);

`ifdef HEX_BUS_ARBITER_WATCHDOG_EN
        // Owner 0 holds request without writing
        for (int k = 0; k < 63; k++) begin
            tick();
            check("wd_quiet", wd_evt_o, 0);
        end
        check("wd_still_gnt", bus.gnt_o, 2'b01);
        tick();
        check("wd_evt", wd_evt_o, 1);
        check("wd_gnt", bus.gnt_o, 0);
        tick();
        check("wd_evt_once", wd_evt_o, 0);
        check("wd_next_gnt", bus.gnt_o, 2'b10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
